// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART TX arbiter: FSM encoding, timing
// defaults and a small index helper.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3,
        ST_HOLD      = 3'd4
    } state_t;

    localparam int CLKS_PER_BIT_DEF = 87;
    localparam int TIMEOUT_CLKS_DEF = 2048;

    // Next requester index with wrap at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, searching upward with wrap.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
)(
    input  logic [NUM_REQ-1:0] i_Req,
    input  logic [IDW-1:0]     i_Ptr,
    output logic [IDW-1:0]     o_Grant,
    output logic               o_Any_Valid
);

    logic           w_found;
    logic [IDW-1:0] w_idx;

    always_comb begin
        o_Grant = i_Ptr;
        w_found = 1'b0;
        w_idx   = i_Ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = IDW'((int'(i_Ptr) + i) % NUM_REQ);
            if (!w_found && i_Req[w_idx]) begin
                o_Grant = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign o_Any_Valid = |i_Req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte streams, with
// packet lock until the last byte, optional inter-byte gap and a watchdog.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no grant active; pick next requester when UART is free
// LOAD      | one-cycle handshake: DV + ready to the granted requester
// WAIT_DONE | byte in flight; wait for UART done (watchdog running)
// GAP       | idle spacing after done before the next decision
// HOLD      | packet locked, waiting for the owner's next byte (watchdog)
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 0,
    parameter int TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
)(
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic [NUM_REQ-1:0]           i_Req_Valid,
    input  logic [NUM_REQ*8-1:0]         i_Req_Byte,
    input  logic [NUM_REQ-1:0]           i_Req_Last,
    output logic [NUM_REQ-1:0]           o_Req_Ready,
    output logic                         o_TX_DV,
    output logic [7:0]                   o_TX_Byte,
    input  logic                         i_TX_Active,
    input  logic                         i_TX_Done,
    output logic [$clog2(NUM_REQ)-1:0]   o_Grant_ID,
    output logic                         o_Busy,
    output logic                         o_Timeout
);

    localparam int                IDW      = $clog2(NUM_REQ);
    localparam int                WDW      = $clog2(TIMEOUT_CLKS) + 1;
    localparam logic [WDW-1:0]    WD_LIMIT = WDW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]        GAP_LOAD = (GAP_CLKS > 0) ? 8'(GAP_CLKS - 1) : 8'd0;

    state_t          r_state;
    logic [IDW-1:0]  r_grant;
    logic [IDW-1:0]  r_rr_ptr;
    logic            r_last;
    logic [WDW-1:0]  r_wd;
    logic [7:0]      r_gap_cnt;
    logic [7:0]      r_tx_byte;
    logic            r_timeout;

    logic [IDW-1:0]  w_pick;
    logic            w_any_valid;
    logic            w_grant_valid;
    logic            w_load_ok;
    logic [7:0]      w_grant_byte;
    logic [IDW-1:0]  w_grant_inc;
    logic [WDW-1:0]  w_wd_next;
    logic            w_wd_expire;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .i_Req       (i_Req_Valid),
        .i_Ptr       (r_rr_ptr),
        .o_Grant     (w_pick),
        .o_Any_Valid (w_any_valid)
    );

    assign w_grant_valid = i_Req_Valid[r_grant];
    assign w_grant_byte  = i_Req_Byte[{r_grant, 3'b000} +: 8];
    assign w_grant_inc   = IDW'(wrap_inc(int'(r_grant), NUM_REQ));
    assign w_wd_next     = (&r_wd) ? r_wd : r_wd + 1'b1;
    assign w_wd_expire   = (w_wd_next == WD_LIMIT);

    // DV and ready are qualified by the live valid so a requester that
    // withdraws during LOAD never sees an accept for a byte it no longer offers.
    assign w_load_ok   = (r_state == ST_LOAD) && w_grant_valid;
    assign o_TX_DV     = w_load_ok;
    assign o_TX_Byte   = w_load_ok ? w_grant_byte : r_tx_byte;
    assign o_Req_Ready = w_load_ok ? (NUM_REQ'(1) << r_grant) : '0;
    assign o_Grant_ID  = r_grant;
    assign o_Busy      = (r_state != ST_IDLE);
    assign o_Timeout   = r_timeout;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            r_last    <= 1'b0;
            r_wd      <= '0;
            r_gap_cnt <= '0;
            r_tx_byte <= 8'h00;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid && !i_TX_Active) begin
                        r_grant <= w_pick;
                        r_state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (w_grant_valid) begin
                        r_tx_byte <= w_grant_byte;
                        r_last    <= i_Req_Last[r_grant];
                        r_wd      <= '0;
                        r_state   <= ST_WAIT_DONE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_WAIT_DONE: begin
                    if (i_TX_Done) begin
                        if (GAP_CLKS > 0) begin
                            r_gap_cnt <= GAP_LOAD;
                            r_state   <= ST_GAP;
                        end else if (r_last) begin
                            r_rr_ptr <= w_grant_inc;
                            r_state  <= ST_IDLE;
                        end else if (w_grant_valid) begin
                            r_state <= ST_LOAD;
                        end else begin
                            r_wd    <= '0;
                            r_state <= ST_HOLD;
                        end
                    end else if (w_wd_expire) begin
                        r_timeout <= 1'b1;
                        r_last    <= 1'b0;
                        r_rr_ptr  <= w_grant_inc;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_wd <= w_wd_next;
                    end
                end

                ST_GAP: begin
                    if (r_gap_cnt == 8'd0) begin
                        if (r_last) begin
                            r_rr_ptr <= w_grant_inc;
                            r_state  <= ST_IDLE;
                        end else if (w_grant_valid) begin
                            r_state <= ST_LOAD;
                        end else begin
                            r_wd    <= '0;
                            r_state <= ST_HOLD;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end

                ST_HOLD: begin
                    if (w_grant_valid) begin
                        r_state <= ST_LOAD;
                    end else if (w_wd_expire) begin
                        r_timeout <= 1'b1;
                        r_last    <= 1'b0;
                        r_rr_ptr  <= w_grant_inc;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_wd <= w_wd_next;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: instance A (no gap, long watchdog) and
// instance B (10-clock gap, 64-clock watchdog) share requesters and reset.
module tb_uart_tx_arbiter;

    localparam int TXLEN = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;

    always #5 clk = ~clk;

    logic [3:0]  req_valid;
    logic [31:0] req_byte;
    logic [3:0]  req_last;

    logic [7:0]  q_data [4][64];
    logic        q_last [4][64];
    int          q_len  [4];
    int          pop    [4] = '{0, 0, 0, 0};
    logic [3:0]  mask;
    logic        use_b;
    logic        en_b;

    logic [3:0] rdy_a, rdy_b;
    logic       dv_a, dv_b;
    logic [7:0] byte_a, byte_b;
    logic       act_a, act_b, done_a, done_b;
    logic [1:0] gid_a, gid_b;
    logic       busy_a, busy_b, to_a, to_b;
    int         scnt_a, scnt_b;

    int checks = 0;
    int failures = 0;

    logic [7:0] la_byte[$];
    logic [1:0] la_gid[$];
    int         la_t[$];
    int         da_t[$];
    logic [7:0] lb_byte[$];
    logic [1:0] lb_gid[$];
    int         lb_t[$];
    int         db_t[$];
    int         tb_t[$];

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(0), .TIMEOUT_CLKS(2048)) dut_a (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Req_Valid (req_valid),
        .i_Req_Byte  (req_byte),
        .i_Req_Last  (req_last),
        .o_Req_Ready (rdy_a),
        .o_TX_DV     (dv_a),
        .o_TX_Byte   (byte_a),
        .i_TX_Active (act_a),
        .i_TX_Done   (done_a),
        .o_Grant_ID  (gid_a),
        .o_Busy      (busy_a),
        .o_Timeout   (to_a)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(10), .TIMEOUT_CLKS(64)) dut_b (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Req_Valid (req_valid),
        .i_Req_Byte  (req_byte),
        .i_Req_Last  (req_last),
        .o_Req_Ready (rdy_b),
        .o_TX_DV     (dv_b),
        .o_TX_Byte   (byte_b),
        .i_TX_Active (act_b),
        .i_TX_Done   (done_b),
        .o_Grant_ID  (gid_b),
        .o_Busy      (busy_b),
        .o_Timeout   (to_b)
    );

    // Requester model: per-requester byte queues, popped on ready.
    always_comb begin
        req_valid = '0;
        req_byte  = '0;
        req_last  = '0;
        for (int k = 0; k < 4; k++) begin
            req_valid[k]       = !mask[k] && (pop[k] < q_len[k]);
            req_byte[8*k +: 8] = q_data[k][pop[k]];
            req_last[k]        = q_last[k][pop[k]];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (use_b ? rdy_b[k] : rdy_a[k]) pop[k] <= pop[k] + 1;
        end
        cyc <= cyc + 1;
        if (dv_a) begin la_byte.push_back(byte_a); la_gid.push_back(gid_a); la_t.push_back(cyc + 1); end
        if (done_a) da_t.push_back(cyc + 1);
        if (dv_b) begin lb_byte.push_back(byte_b); lb_gid.push_back(gid_b); lb_t.push_back(cyc + 1); end
        if (done_b) db_t.push_back(cyc + 1);
        if (to_b) tb_t.push_back(cyc + 1);
    end

    // UART_TX stubs: busy for TXLEN clocks after DV, then a one-cycle done.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act_a <= 1'b0; done_a <= 1'b0; scnt_a <= 0;
        end else begin
            done_a <= 1'b0;
            if (dv_a) begin
                act_a <= 1'b1; scnt_a <= TXLEN;
            end else if (act_a) begin
                if (scnt_a == 1) begin act_a <= 1'b0; done_a <= 1'b1; end
                scnt_a <= scnt_a - 1;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            act_b <= 1'b0; done_b <= 1'b0; scnt_b <= 0;
        end else begin
            done_b <= 1'b0;
            if (dv_b && en_b) begin
                act_b <= 1'b1; scnt_b <= TXLEN;
            end else if (act_b) begin
                if (scnt_b == 1) begin act_b <= 1'b0; done_b <= 1'b1; end
                scnt_b <= scnt_b - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] b, input logic l);
        q_data[k][q_len[k]] = b;
        q_last[k][q_len[k]] = l;
        q_len[k]++;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
    endtask

    task automatic wait_la(input int n, input string tag);
        int t = 0;
        while (la_byte.size() < n && t < 400) begin @(negedge clk); t++; end
        check(tag, 32'(la_byte.size() >= n), 32'd1);
    endtask

    task automatic wait_lb(input int n, input string tag);
        int t = 0;
        while (lb_byte.size() < n && t < 400) begin @(negedge clk); t++; end
        check(tag, 32'(lb_byte.size() >= n), 32'd1);
    endtask

    task automatic wait_idle_a();
        int t = 0;
        while ((busy_a || act_a) && t < 400) begin @(negedge clk); t++; end
        check("idle_a_reached", 32'(!busy_a && !act_a), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int c0, b, db, t0, tw;
        logic found;
        logic [7:0] exp_f [5];
        logic [7:0] exp_l [5];

        mask  = '0;
        use_b = 1'b0;
        en_b  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            q_len[k] = 0;
            for (int j = 0; j < 64; j++) begin q_data[k][j] = 8'h00; q_last[k][j] = 1'b0; end
        end
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_outs_a", {15'd0, dv_a, byte_a, rdy_a, gid_a, busy_a, to_a}, 32'd0);
        check("rst_outs_b", {15'd0, dv_b, byte_b, rdy_b, gid_b, busy_b, to_b}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request: DV two cycles after valid rises
        c0 = cyc;
        push(0, 8'h3F, 1'b1);
        wait_la(1, "single_dv_seen");
        check("single_byte", la_byte[0], 8'h3F);
        check("single_gid", la_gid[0], 2'd0);
        check("single_latency", la_t[0] - c0, 2);
        wait_idle_a();

        // Pointer advanced to 1: req1 wins over req0
        push(0, 8'h40, 1'b1);
        push(1, 8'h41, 1'b1);
        wait_la(3, "rrptr_dv_seen");
        check("rrptr_first", la_byte[1], 8'h41);
        check("rrptr_second", la_byte[2], 8'h40);
        wait_idle_a();

        // Fairness from pointer 0
        do_reset();
        b = la_byte.size();
        push(0, 8'hA0, 1'b1); push(0, 8'hA0, 1'b1);
        push(1, 8'hA1, 1'b1); push(2, 8'hA2, 1'b1); push(3, 8'hA3, 1'b1);
        exp_f = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
        wait_la(b + 5, "fair_dv_seen");
        for (int i = 0; i < 5; i++) check($sformatf("fair_order_%0d", i), la_byte[b + i], exp_f[i]);
        wait_idle_a();

        // Packet lock with a HOLD period of 500 clocks
        do_reset();
        b  = la_byte.size();
        db = da_t.size();
        push(2, 8'h11, 1'b0);
        wait_la(b + 1, "lock_first_seen");
        push(0, 8'h50, 1'b1);
        push(1, 8'h51, 1'b1);
        repeat (500) @(negedge clk);
        check("hold_no_grant", la_byte.size(), b + 1);
        check("hold_gid", gid_a, 2'd2);
        check("hold_busy", busy_a, 1'b1);
        push(2, 8'h22, 1'b0);
        push(2, 8'h33, 1'b1);
        exp_l = '{8'h11, 8'h22, 8'h33, 8'h50, 8'h51};
        wait_la(b + 5, "lock_dv_seen");
        for (int i = 0; i < 5; i++) check($sformatf("lock_order_%0d", i), la_byte[b + i], exp_l[i]);
        check("lock_b2b_latency", la_t[b + 2] - da_t[db + 1], 1);
        wait_idle_a();

        // Asynchronous reset while waiting for done
        b = la_byte.size();
        push(1, 8'hD1, 1'b1);
        wait_la(b + 1, "rst_mid_dv_seen");
        repeat (3) @(negedge clk);
        check("pre_rst_busy", busy_a, 1'b1);
        #2 rst = 1'b1;
        #1 check("async_rst_outs", {15'd0, dv_a, byte_a, rdy_a, gid_a, busy_a, to_a}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        push(3, 8'hE3, 1'b1);
        wait_la(b + 2, "post_rst_dv_seen");
        check("post_rst_gid", la_gid[b + 1], 2'd3);
        check("post_rst_byte", la_byte[b + 1], 8'hE3);
        wait_idle_a();

        // Valid withdrawn during LOAD: no DV, no ready, back to IDLE
        b = la_byte.size();
        push(2, 8'h77, 1'b1);
        @(posedge clk);
        @(negedge clk);
        mask[2] = 1'b1;
        #1;
        check("drop_no_dv", dv_a, 1'b0);
        check("drop_no_ready", rdy_a, 4'd0);
        check("drop_in_load", busy_a, 1'b1);
        @(negedge clk);
        check("drop_to_idle", busy_a, 1'b0);
        mask[2] = 1'b0;
        wait_la(b + 1, "drop_retry_seen");
        check("drop_retry_byte", la_byte[b], 8'h77);
        check("drop_retry_gid", la_gid[b], 2'd2);
        wait_idle_a();

        // Gap of 10 clocks on instance B
        @(negedge clk); rst = 1'b1; use_b = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        b  = lb_byte.size();
        db = db_t.size();
        push(1, 8'hAA, 1'b0);
        push(1, 8'hBB, 1'b1);
        wait_lb(b + 2, "gap_dv_seen");
        check("gap_first_byte", lb_byte[b], 8'hAA);
        check("gap_second_byte", lb_byte[b + 1], 8'hBB);
        check("gap_gid", lb_gid[b + 1], 2'd1);
        check("gap_distance", lb_t[b + 1] - db_t[db], 11);
        repeat (30) @(negedge clk);

        // Watchdog on instance B with a UART that never completes
        en_b = 1'b0;
        do_reset();
        b  = lb_byte.size();
        t0 = tb_t.size();
        push(0, 8'hC0, 1'b1);
        push(0, 8'hC2, 1'b1);
        push(1, 8'hC1, 1'b1);
        found = 1'b0;
        tw = 0;
        while (!found && tw < 200) begin
            @(negedge clk);
            tw++;
            if (to_b) found = 1'b1;
        end
        check("wd_fired", found, 1'b1);
        check("wd_idle", busy_b, 1'b0);
        wait_lb(b + 2, "wd_next_dv_seen");
        check("wd_first_byte", lb_byte[b], 8'hC0);
        check("wd_first_gid", lb_gid[b], 2'd0);
        check("wd_delay", tb_t[t0] - lb_t[b], 64);
        check("wd_next_gid", lb_gid[b + 1], 2'd1);
        check("wd_next_byte", lb_byte[b + 1], 8'hC1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
